// File: rtl/uart_pos_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_pos_tx_scheduler
//
// Purpose:
//   Sequences tank-position frames onto a byte-wide UART transmitter. On a
//   periodic tick (when enabled) or an explicit request, the block snapshots
//   the X/Y position. It then sends a 6-byte frame one byte at a time and
//   handshakes each byte on the transmitter's done tick. Each byte wait is
//   protected by a watchdog. If the watchdog expires, the frame is dropped.
//
//   Frame layout (byte index 0..5):
//     0: HEADER
//     1: {6'b0, X[9:8]}
//     2: X[7:0]
//     3: {6'b0, Y[9:8]}
//     4: Y[7:0]
//     5: XOR of bytes 1..4
//
// Parameters:
//   PERIOD      clk cycles between automatic frames
//   PERIOD_BIT  width of the period counter
//   HEADER      frame start byte
//   TIMEOUT     max clk cycles to wait for i_tx_done_tick per byte
//   TO_BIT      width of the timeout counter (holds 0..TIMEOUT-1)
//
// Ports:
//   i_clk           system clock
//   i_reset         synchronous, active-high reset
//   i_enable        1 = periodic frames enabled (i_send_req always honoured)
//   i_send_req      one-cycle pulse requesting one frame
//   i_x_pos         tank X position (10 bits)
//   i_y_pos         tank Y position (10 bits)
//   i_tx_done_tick  from the transmitter: current byte fully shifted out
//   o_tx_start      one-cycle pulse: start transmitting o_tx_data
//   o_tx_data       byte to transmit; registered and held until next start
//   o_busy          high while a frame is in progress
//   o_frame_done    one-cycle pulse after the last byte's done tick
//   o_timeout_err   one-cycle pulse when a byte handshake times out
// -----------------------------------------------------------------------------
module uart_pos_tx_scheduler #(
    parameter int          PERIOD     = 1666667,
    parameter int          PERIOD_BIT = 21,
    parameter logic [7:0]  HEADER     = 8'hA5,
    parameter int          TIMEOUT    = 32768,
    parameter int          TO_BIT     = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_send_req,
    input  logic [9:0] i_x_pos,
    input  logic [9:0] i_y_pos,
    input  logic       i_tx_done_tick,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [PERIOD_BIT-1:0] PERIOD_LAST = PERIOD_BIT'(PERIOD - 1);
    localparam logic [TO_BIT-1:0]     TO_LAST     = TO_BIT'(TIMEOUT - 1);
    localparam logic [2:0]            LAST_IDX    = 3'd5;

    state_t                r_state;
    state_t                w_state_next;

    logic [PERIOD_BIT-1:0] r_period_cnt;
    logic [TO_BIT-1:0]     r_to_cnt;
    logic [9:0]            r_x_snap;
    logic [9:0]            r_y_snap;
    logic [2:0]            r_idx;
    logic                  r_pending;
    logic [7:0]            r_tx_data;
    logic                  r_frame_done;
    logic                  r_timeout_err;

    logic                  w_ptick;
    logic                  w_trigger;
    logic                  w_start_frame;
    logic                  w_byte_done;
    logic                  w_last_byte;
    logic                  w_timeout;
    logic [7:0]            w_chk;
    logic [7:0]            w_next_byte;

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    assign w_ptick       = (r_period_cnt == PERIOD_LAST) & i_enable;
    assign w_trigger     = i_send_req | w_ptick;
    assign w_start_frame = (r_state == ST_IDLE) & (w_trigger | r_pending);
    assign w_byte_done   = (r_state == ST_WAIT) & i_tx_done_tick;
    assign w_last_byte   = (r_idx == LAST_IDX);
    // A done tick on the final watchdog cycle still completes the byte.
    assign w_timeout     = (r_state == ST_WAIT) & ~i_tx_done_tick &
                           (r_to_cnt == TO_LAST);

    // The checksum comes from the snapshot, so it always matches the bytes sent.
    assign w_chk = {6'b0, r_x_snap[9:8]} ^ r_x_snap[7:0] ^
                   {6'b0, r_y_snap[9:8]} ^ r_y_snap[7:0];

    // Selects the byte that follows r_idx. It is loaded into o_tx_data on the
    // same edge that enters SEND, so data is valid together with o_tx_start.
    always_comb begin
        w_next_byte = w_chk;
        case (r_idx)
            3'd0:    w_next_byte = {6'b0, r_x_snap[9:8]};
            3'd1:    w_next_byte = r_x_snap[7:0];
            3'd2:    w_next_byte = {6'b0, r_y_snap[9:8]};
            3'd3:    w_next_byte = r_y_snap[7:0];
            default: w_next_byte = w_chk;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_frame) begin
                    w_state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_byte_done) begin
                    w_state_next = w_last_byte ? ST_IDLE : ST_SEND;
                end else if (w_timeout) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_tx_start    = (r_state == ST_SEND);
        o_busy        = (r_state != ST_IDLE);
        o_tx_data     = r_tx_data;
        o_frame_done  = r_frame_done;
        o_timeout_err = r_timeout_err;
    end

    // -------------------------------------------------------------------------
    // Period counter: free-running regardless of FSM state
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_period_cnt <= '0;
        end else if (r_period_cnt == PERIOD_LAST) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Frame datapath: snapshot, byte index, pending flag, watchdog, pulses
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_to_cnt      <= '0;
            r_x_snap      <= '0;
            r_y_snap      <= '0;
            r_idx         <= '0;
            r_pending     <= 1'b0;
            r_tx_data     <= '0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_frame_done  <= w_byte_done & w_last_byte;
            r_timeout_err <= w_timeout;

            // Only one request is remembered. Any extra triggers seen while
            // busy merge into it.
            if (w_start_frame) begin
                r_pending <= 1'b0;
            end else if ((r_state != ST_IDLE) && w_trigger) begin
                r_pending <= 1'b1;
            end

            if (w_start_frame) begin
                r_x_snap  <= i_x_pos;
                r_y_snap  <= i_y_pos;
                r_idx     <= '0;
                r_tx_data <= HEADER;
            end

            if (r_state == ST_SEND) begin
                r_to_cnt <= '0;
            end

            if (r_state == ST_WAIT) begin
                if (w_byte_done) begin
                    if (!w_last_byte) begin
                        r_idx     <= r_idx + 3'd1;
                        r_tx_data <= w_next_byte;
                    end
                end else if (!w_timeout) begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_pos_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_pos_tx_scheduler
//
// Purpose:
//   Self-checking bench for uart_pos_tx_scheduler. A behavioural transmitter
//   answers each start pulse with a done tick after a random or directed
//   latency. Expected frame bytes come from plain arithmetic on the X/Y values
//   that were applied when the frame was triggered.
// -----------------------------------------------------------------------------
module tb_uart_pos_tx_scheduler;

    localparam int PERIOD  = 50;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       send_req;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       tx_done;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
    logic       frame_done;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;   // edges since the last reset edge; equals period phase

    uart_pos_tx_scheduler #(
        .PERIOD     (PERIOD),
        .PERIOD_BIT (6),
        .HEADER     (8'hA5),
        .TIMEOUT    (TIMEOUT),
        .TO_BIT     (6)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_send_req     (send_req),
        .i_x_pos        (x_pos),
        .i_y_pos        (y_pos),
        .i_tx_done_tick (tx_done),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .o_busy         (busy),
        .o_frame_done   (frame_done),
        .o_timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Expected frame byte k for position (x, y).
    function automatic logic [7:0] exp_byte(input logic [9:0] x, input logic [9:0] y,
                                            input int k);
        int unsigned xh, xl, yh, yl;
        xh = 32'(x) / 256;
        xl = 32'(x) % 256;
        yh = 32'(y) / 256;
        yl = 32'(y) % 256;
        case (k)
            0:       return 8'hA5;
            1:       return 8'(xh);
            2:       return 8'(xl);
            3:       return 8'(yh);
            4:       return 8'(yl);
            default: return 8'(xh ^ xl ^ yh ^ yl);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic randomize_xy();
        x_pos = 10'($urandom);
        y_pos = 10'($urandom);
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        step();
        send_req = 1'b0;
    endtask

    task automatic quiet(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (tx_start !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 ||
                timeout_err !== 1'b0) bad++;
        end
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (tx_start !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check("wait_start", 32'(tx_start), 32'd1);
    endtask

    // Serves one frame whose first tx_start is visible in the current cycle.
    // lat_fix > 0 gives a fixed done latency, otherwise the latency is random.
    // withhold >= 0 suppresses the done tick for that byte, which forces a timeout.
    // req_bits[k] pulses send_req in the first wait cycle of byte k.
    // X/Y change every cycle, which checks that the snapshot is used.
    task automatic serve_frame(input logic [9:0] ex, input logic [9:0] ey,
                               input int lat_fix, input int withhold,
                               input logic [5:0] req_bits);
        int lat;
        int bad;
        for (int k = 0; k < 6; k++) begin
            check("tx_start", 32'(tx_start), 32'd1);
            check("tx_data", 32'(tx_data), 32'(exp_byte(ex, ey, k)));
            check("busy", 32'(busy), 32'd1);
            bad = 0;
            if (k == withhold) begin
                for (int c = 1; c <= TIMEOUT; c++) begin
                    step();
                    if (tx_start !== 1'b0 || frame_done !== 1'b0 ||
                        timeout_err !== 1'b0 || busy !== 1'b1) bad++;
                    send_req = req_bits[k] && (c == 1);
                    randomize_xy();
                end
                check("wait_quiet_to", 32'(bad), 32'd0);
                step();
                send_req = 1'b0;
                randomize_xy();
                $display("frame x=%h y=%h timed out at byte %0d", ex, ey, k);
                check("timeout_err", 32'(timeout_err), 32'd1);
                check("busy_after_to", 32'(busy), 32'd0);
                check("no_done_on_to", 32'(frame_done), 32'd0);
                return;
            end
            lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, TIMEOUT));
            for (int c = 1; c <= lat; c++) begin
                step();
                if (tx_start !== 1'b0 || frame_done !== 1'b0 ||
                    timeout_err !== 1'b0 || busy !== 1'b1 ||
                    tx_data !== exp_byte(ex, ey, k)) bad++;
                tx_done  = (c == lat);
                send_req = req_bits[k] && (c == 1);
                randomize_xy();
            end
            check("wait_quiet", 32'(bad), 32'd0);
            step();
            tx_done  = 1'b0;
            send_req = 1'b0;
            randomize_xy();
        end
        $display("frame x=%h y=%h sent, chk=%h", ex, ey, exp_byte(ex, ey, 5));
        check("frame_done", 32'(frame_done), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("tx_data_held", 32'(tx_data), 32'(exp_byte(ex, ey, 5)));
    endtask

    initial begin
        logic [9:0] xa, ya;
        int         t_prev;

        reset    = 1'b1;
        enable   = 1'b0;
        send_req = 1'b0;
        tx_done  = 1'b0;
        x_pos    = '0;
        y_pos    = '0;

        // Reset state
        repeat (3) step();
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        cyc   = 0;

        // Directed frame; done lands on the last watchdog cycle (done wins)
        x_pos = 10'h2A5;
        y_pos = 10'h133;
        pulse_req();
        serve_frame(10'h2A5, 10'h133, TIMEOUT, -1, 6'b0);
        check("chk_literal", 32'(tx_data), 32'h95);
        quiet("idle_after_frame", 5);

        // Reset mid-frame with a pending request queued
        randomize_xy();
        pulse_req();
        repeat (3) step();
        pulse_req();
        reset = 1'b1;
        step();
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_flags", 32'({frame_done, timeout_err}), 32'd0);
        repeat (2) step();
        reset = 1'b0;
        cyc   = 0;
        quiet("after_midrst", 30);

        // Request during byte 2 -> one extra frame right after frame_done;
        // two requests during that frame -> exactly one more
        randomize_xy();
        xa = x_pos;
        ya = y_pos;
        pulse_req();
        serve_frame(xa, ya, 0, -1, 6'b000100);
        xa = x_pos;
        ya = y_pos;
        step();
        serve_frame(xa, ya, 0, -1, 6'b001010);
        xa = x_pos;
        ya = y_pos;
        step();
        serve_frame(xa, ya, 0, -1, 6'b0);
        quiet("merged_pending", 20);

        // Timeout on byte 3, then a clean frame from byte 0
        randomize_xy();
        xa = x_pos;
        ya = y_pos;
        pulse_req();
        serve_frame(xa, ya, 0, 3, 6'b0);
        quiet("after_timeout", 5);
        randomize_xy();
        xa = x_pos;
        ya = y_pos;
        pulse_req();
        serve_frame(xa, ya, 0, -1, 6'b0);

        // Timeout with a pending request -> pending frame served afterwards
        randomize_xy();
        xa = x_pos;
        ya = y_pos;
        pulse_req();
        serve_frame(xa, ya, 0, 1, 6'b000010);
        xa = x_pos;
        ya = y_pos;
        step();
        serve_frame(xa, ya, 0, -1, 6'b0);

        // Stray done tick while idle is ignored
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        quiet("stray_done", 10);

        // Periodic frames; first one coincides with send_req (one frame only)
        enable = 1'b1;
        for (int i = 0; i < PERIOD && (cyc % PERIOD) != PERIOD - 1; i++) step();
        randomize_xy();
        xa = x_pos;
        ya = y_pos;
        pulse_req();
        check("period_phase0", 32'(cyc % PERIOD), 32'd0);
        serve_frame(xa, ya, 1, -1, 6'b0);
        t_prev = cyc - 12;
        for (int f = 0; f < 2; f++) begin
            wait_start(PERIOD + 10);
            check("period_spacing", 32'(cyc - t_prev), 32'(PERIOD));
            t_prev = cyc;
            serve_frame(x_pos, y_pos, 1, -1, 6'b0);
        end
        enable = 1'b0;
        quiet("enable_off", 3 * PERIOD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
